// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   Round-robin arbiter sharing the single framebuffer write port among
//   NUM_REQ requesters in the gpu_clk domain. One pixel write is accepted
//   per cycle at most. A requester can lock the port for a multi-beat
//   burst. Accepted in-range writes appear on the framebuffer write
//   outputs one cycle later. Out-of-range writes still complete their
//   handshake, but they are dropped and counted in a saturating counter.
//
// Ports
//   gpu_clk      in   clock; all state updates on the rising edge
//   reset        in   synchronous, active-high
//   req_valid    in   [NUM_REQ]            per-requester write request
//   req_lock     in   [NUM_REQ]            burst lock, sampled with an accepted beat
//   req_addr     in   [NUM_REQ*ADDR_BITS]  linear pixel address, slice i*ADDR_BITS
//   req_data     in   [NUM_REQ*DATA_BITS]  palette index, slice i*DATA_BITS
//   req_ready    out  [NUM_REQ]            one-hot or zero grant (combinational)
//   fb_wr_en     out                       registered write strobe
//   fb_addr      out  [ADDR_BITS]          registered write address
//   fb_wr_data   out  [DATA_BITS]          registered write data
//   grant_id     out  [$clog2(NUM_REQ)]    index of the last accepted requester
//   locked       out                       high while the port is locked
//   drop_count   out  [DROP_BITS]          saturating count of dropped beats
module fb_write_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned RESOLUTION_X   = 400,
  parameter int unsigned RESOLUTION_Y   = 300,
  parameter int unsigned PALETTE_LENGTH = 256,
  parameter int unsigned DROP_BITS      = 16,
  localparam int unsigned DATA_BITS     = $clog2(PALETTE_LENGTH),
  localparam int unsigned ADDR_BITS     = $clog2(RESOLUTION_X * RESOLUTION_Y),
  localparam int unsigned ID_BITS       = $clog2(NUM_REQ)
) (
  input  logic                           gpu_clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_lock,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           fb_wr_en,
  output logic [ADDR_BITS-1:0]           fb_addr,
  output logic [DATA_BITS-1:0]           fb_wr_data,
  output logic [ID_BITS-1:0]             grant_id,
  output logic                           locked,
  output logic [DROP_BITS-1:0]           drop_count
);

  localparam int unsigned PIXELS = RESOLUTION_X * RESOLUTION_Y;

  typedef enum logic {
    ST_ARB,
    ST_LOCKED
  } state_t;

  state_t                 state_q, state_d;
  logic [ID_BITS-1:0]     last_q, last_d;
  logic [ID_BITS-1:0]     grant_q, grant_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [DROP_BITS-1:0]   drop_q, drop_d;

  logic [ID_BITS-1:0]     cand;
  logic [ID_BITS-1:0]     sel_idx;
  logic                   sel_hit;
  logic                   accept;
  logic [ADDR_BITS-1:0]   sel_addr;
  logic [DATA_BITS-1:0]   sel_data;
  logic                   sel_lock;
  logic                   in_range;

  // Grant selection: in LOCKED the owner (last_q) is always offered the
  // port; in ARB the first valid requester after last_q wins.
  always_comb begin
    req_ready = '0;
    sel_idx   = last_q;
    sel_hit   = 1'b0;
    cand      = '0;
    if (state_q == ST_LOCKED) begin
      sel_hit = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
        cand = ID_BITS'((32'(last_q) + k) % NUM_REQ);
        if (!sel_hit && req_valid[cand]) begin
          sel_idx = cand;
          sel_hit = 1'b1;
        end
      end
    end
    if (sel_hit) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  assign accept   = sel_hit & req_valid[sel_idx];
  assign sel_addr = req_addr[sel_idx*ADDR_BITS +: ADDR_BITS];
  assign sel_data = req_data[sel_idx*DATA_BITS +: DATA_BITS];
  assign sel_lock = req_lock[sel_idx];
  assign in_range = 32'(sel_addr) < PIXELS;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    drop_d  = drop_q;

    case (state_q)
      ST_ARB: begin
        if (accept && sel_lock) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // Owner beat or owner idle: either way the owner's lock bit alone
        // decides whether the port stays held.
        if (!req_lock[last_q]) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase

    if (accept) begin
      last_d  = sel_idx;
      grant_d = sel_idx;
      if (in_range) begin
        wr_en_d = 1'b1;
        addr_d  = sel_addr;
        data_d  = sel_data;
      end else if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge gpu_clk) begin
    if (reset) begin
      state_q <= ST_ARB;
      last_q  <= ID_BITS'(NUM_REQ - 1);
      grant_q <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign fb_wr_en   = wr_en_q;
  assign fb_addr    = addr_q;
  assign fb_wr_data = data_q;
  assign grant_id   = grant_q;
  assign locked     = (state_q == ST_LOCKED);
  assign drop_count = drop_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter
//   Self-checking bench for fb_write_arbiter at default parameters
//   (2 requesters, 400x300, 256-entry palette, 16-bit drop counter).
module tb_fb_write_arbiter;

  localparam int unsigned N     = 2;
  localparam int unsigned AB    = 17;
  localparam int unsigned DB    = 8;
  localparam int unsigned PIX   = 120000;
  localparam int unsigned DMAX  = 65535;

  logic              gpu_clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_lock;
  logic [N*AB-1:0]   req_addr;
  logic [N*DB-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fb_wr_en;
  logic [AB-1:0]     fb_addr;
  logic [DB-1:0]     fb_wr_data;
  logic [0:0]        grant_id;
  logic              locked;
  logic [15:0]       drop_count;

  fb_write_arbiter #(
    .NUM_REQ(N),
    .RESOLUTION_X(400),
    .RESOLUTION_Y(300),
    .PALETTE_LENGTH(256),
    .DROP_BITS(16)
  ) dut (
    .gpu_clk(gpu_clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_lock(req_lock),
    .req_addr(req_addr),
    .req_data(req_data),
    .req_ready(req_ready),
    .fb_wr_en(fb_wr_en),
    .fb_addr(fb_addr),
    .fb_wr_data(fb_wr_data),
    .grant_id(grant_id),
    .locked(locked),
    .drop_count(drop_count)
  );

  always #5 gpu_clk = ~gpu_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge gpu_clk);
    #1;
  endtask

  task automatic apply(input logic [1:0] v, input logic [1:0] l,
                       input logic [AB-1:0] a0, input logic [AB-1:0] a1,
                       input logic [DB-1:0] d0, input logic [DB-1:0] d1);
    req_valid = v;
    req_lock  = l;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    apply(2'b00, 2'b00, '0, '0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Directed vector table: inputs for one cycle, expected combinational
  // ready during that cycle and registered outputs after the edge.
  typedef struct {
    logic [1:0]    valid;
    logic [1:0]    lock;
    logic [AB-1:0] a0;
    logic [AB-1:0] a1;
    logic [DB-1:0] d0;
    logic [DB-1:0] d1;
    logic [1:0]    e_ready;
    logic          e_en;
    logic [AB-1:0] e_addr;
    logic [DB-1:0] e_data;
    logic          e_grant;
    logic          e_locked;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  bit      m_locked;
  int      m_last;
  int      m_grant;
  bit      m_en;
  int      m_addr;
  int      m_data;
  int      m_drop;

  function automatic logic [1:0] model_ready(input logic [1:0] v);
    logic [1:0] r;
    r = '0;
    if (m_locked) begin
      r[m_last] = 1'b1;
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (r == '0 && v[c]) r[c] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_locked = 0;
    m_last   = N - 1;
    m_grant  = 0;
    m_en     = 0;
    m_addr   = 0;
    m_data   = 0;
    m_drop   = 0;
  endtask

  task automatic model_step(input logic [1:0] v, input logic [1:0] l,
                            input logic [1:0] rdy, input int addr[N], input int data[N]);
    int  acc;
    bit  nxt_locked;
    acc = -1;
    for (int r = 0; r < N; r++) if (v[r] && rdy[r]) acc = r;
    if (!m_locked)    nxt_locked = (acc >= 0) && l[acc];
    else if (acc >= 0) nxt_locked = l[acc];
    else              nxt_locked = l[m_last];
    m_en = 0;
    if (acc >= 0) begin
      m_last  = acc;
      m_grant = acc;
      if (addr[acc] < PIX) begin
        m_en   = 1;
        m_addr = addr[acc];
        m_data = data[acc];
      end else if (m_drop < DMAX) begin
        m_drop = m_drop + 1;
      end
    end
    m_locked = nxt_locked;
  endtask

  initial begin
    logic [AB-1:0] oor;
    logic [1:0]    exp_r;
    bit            pv[N];
    bit            pl[N];
    int            pa[N];
    int            pd[N];
    bit            hold[N];
    bit            rst;
    logic [1:0]    vv;
    logic [1:0]    ll;

    req_valid = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_data  = '0;
    reset     = 1'b1;
    tick();
    do_reset();

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      check("idle_ready", 32'(req_ready), 32'd0);
      check("idle_en", 32'(fb_wr_en), 32'd0);
      check("idle_grant", 32'(grant_id), 32'd0);
      check("idle_drop", 32'(drop_count), 32'd0);
      tick();
    end
    check("idle_locked", 32'(locked), 32'd0);
    check("idle_addr", 32'(fb_addr), 32'd0);

    //        valid  lock   a0   a1   d0 d1  ready  en addr dat g  lk
    tbl.push_back('{2'b11, 2'b00, 10, 20, 5, 7, 2'b01, 1, 10, 5, 0, 0});
    tbl.push_back('{2'b11, 2'b00, 10, 20, 5, 7, 2'b10, 1, 20, 7, 1, 0});
    tbl.push_back('{2'b11, 2'b00, 10, 20, 5, 7, 2'b01, 1, 10, 5, 0, 0});
    tbl.push_back('{2'b11, 2'b00, 10, 20, 5, 7, 2'b10, 1, 20, 7, 1, 0});
    tbl.push_back('{2'b11, 2'b10, 10, 100, 5, 7, 2'b01, 1, 10, 5, 0, 0});
    tbl.push_back('{2'b11, 2'b10, 10, 100, 5, 7, 2'b10, 1, 100, 7, 1, 1});
    tbl.push_back('{2'b11, 2'b10, 10, 101, 5, 7, 2'b10, 1, 101, 7, 1, 1});
    tbl.push_back('{2'b11, 2'b10, 10, 102, 5, 7, 2'b10, 1, 102, 7, 1, 1});
    tbl.push_back('{2'b11, 2'b00, 10, 103, 5, 7, 2'b10, 1, 103, 7, 1, 0});
    tbl.push_back('{2'b11, 2'b00, 10, 20, 5, 7, 2'b01, 1, 10, 5, 0, 0});
    tbl.push_back('{2'b00, 2'b00, 10, 20, 5, 7, 2'b00, 0, 10, 5, 0, 0});
    tbl.push_back('{2'b01, 2'b00, 30, 20, 6, 7, 2'b01, 1, 30, 6, 0, 0});
    tbl.push_back('{2'b01, 2'b00, 31, 20, 6, 7, 2'b01, 1, 31, 6, 0, 0});
    tbl.push_back('{2'b10, 2'b00, 31, 40, 6, 8, 2'b10, 1, 40, 8, 1, 0});
    tbl.push_back('{2'b10, 2'b00, 31, 41, 6, 8, 2'b10, 1, 41, 8, 1, 0});

    foreach (tbl[i]) begin
      apply(tbl[i].valid, tbl[i].lock, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      #1;
      check($sformatf("tbl%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      tick();
      check($sformatf("tbl%0d_en", i), 32'(fb_wr_en), 32'(tbl[i].e_en));
      check($sformatf("tbl%0d_addr", i), 32'(fb_addr), 32'(tbl[i].e_addr));
      check($sformatf("tbl%0d_data", i), 32'(fb_wr_data), 32'(tbl[i].e_data));
      check($sformatf("tbl%0d_grant", i), 32'(grant_id), 32'(tbl[i].e_grant));
      check($sformatf("tbl%0d_locked", i), 32'(locked), 32'(tbl[i].e_locked));
    end

    // Owner locks, goes idle holding the lock, then releases without a beat
    do_reset();
    apply(2'b01, 2'b01, 200, 300, 1, 2);
    #1 check("lk_first_ready", 32'(req_ready), 32'b01);
    tick();
    check("lk_first_en", 32'(fb_wr_en), 32'd1);
    check("lk_first_locked", 32'(locked), 32'd1);
    for (int i = 0; i < 2; i++) begin
      apply(2'b10, 2'b01, 200, 300, 1, 2);
      #1 check("lk_idle_ready", 32'(req_ready), 32'b01);
      tick();
      check("lk_idle_en", 32'(fb_wr_en), 32'd0);
      check("lk_idle_locked", 32'(locked), 32'd1);
    end
    apply(2'b10, 2'b00, 200, 300, 1, 2);
    #1 check("lk_rel_ready", 32'(req_ready), 32'b01);
    tick();
    check("lk_rel_en", 32'(fb_wr_en), 32'd0);
    check("lk_rel_locked", 32'(locked), 32'd0);
    apply(2'b10, 2'b00, 200, 300, 1, 2);
    #1 check("lk_after_ready", 32'(req_ready), 32'b10);
    tick();
    check("lk_after_en", 32'(fb_wr_en), 32'd1);
    check("lk_after_addr", 32'(fb_addr), 32'd300);
    check("lk_after_grant", 32'(grant_id), 32'd1);

    // Out-of-range drops and counter saturation
    do_reset();
    apply(2'b01, 2'b00, 120000, 0, 9, 0);
    #1 check("drop_ready", 32'(req_ready), 32'b01);
    tick();
    check("drop_en", 32'(fb_wr_en), 32'd0);
    check("drop_cnt1", 32'(drop_count), 32'd1);
    check("drop_addr_held", 32'(fb_addr), 32'd0);
    check("drop_grant", 32'(grant_id), 32'd0);
    for (int i = 0; i < 65533; i++) begin
      oor = AB'(PIX + $urandom_range(0, 131071 - PIX));
      apply(2'b01, 2'b00, oor, 0, 9, 0);
      tick();
    end
    check("drop_cnt_fffe", 32'(drop_count), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      apply(2'b01, 2'b00, 131071, 0, 9, 0);
      tick();
    end
    check("drop_cnt_sat", 32'(drop_count), 32'hFFFF);
    check("drop_sat_en", 32'(fb_wr_en), 32'd0);
    apply(2'b01, 2'b00, 119999, 0, 3, 0);
    tick();
    check("edge_in_en", 32'(fb_wr_en), 32'd1);
    check("edge_in_addr", 32'(fb_addr), 32'd119999);
    check("edge_in_data", 32'(fb_wr_data), 32'd3);
    check("edge_in_drop", 32'(drop_count), 32'hFFFF);

    // Reset in the same cycle as an accepted locked beat
    do_reset();
    apply(2'b10, 2'b10, 0, 60, 0, 4);
    #1 check("rst_pre_ready", 32'(req_ready), 32'b10);
    tick();
    check("rst_pre_locked", 32'(locked), 32'd1);
    check("rst_pre_addr", 32'(fb_addr), 32'd60);
    apply(2'b10, 2'b10, 0, 50, 0, 4);
    reset = 1'b1;
    #1 check("rst_same_ready", 32'(req_ready), 32'b10);
    tick();
    reset = 1'b0;
    check("rst_en", 32'(fb_wr_en), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_addr", 32'(fb_addr), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    apply(2'b11, 2'b00, 70, 80, 1, 2);
    #1 check("rst_next_ready", 32'(req_ready), 32'b01);
    tick();
    check("rst_next_grant", 32'(grant_id), 32'd0);
    check("rst_next_addr", 32'(fb_addr), 32'd70);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int r = 0; r < N; r++) begin
      hold[r] = 0;
      pv[r] = 0;
      pl[r] = 0;
      pa[r] = 0;
      pd[r] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int r = 0; r < N; r++) begin
        if (!hold[r]) begin
          pv[r] = ($urandom_range(0, 9) < 7);
          pl[r] = ($urandom_range(0, 9) < 3);
          case ($urandom_range(0, 19))
            0:       pa[r] = PIX - 1;
            1:       pa[r] = PIX;
            2, 3:    pa[r] = PIX + int'($urandom_range(0, 131071 - PIX));
            default: pa[r] = int'($urandom_range(0, PIX - 1));
          endcase
          pd[r] = int'($urandom_range(0, 255));
        end
        vv[r] = pv[r];
        ll[r] = pl[r];
        req_addr[r*AB +: AB] = AB'(pa[r]);
        req_data[r*DB +: DB] = DB'(pd[r]);
      end
      req_valid = vv;
      req_lock  = ll;
      rst = ($urandom_range(0, 199) == 0);
      reset = rst;
      #1;
      exp_r = model_ready(vv);
      check("rnd_ready", 32'(req_ready), 32'(exp_r));
      for (int r = 0; r < N; r++) hold[r] = pv[r] && !exp_r[r];
      tick();
      if (rst) model_reset();
      else     model_step(vv, ll, exp_r, pa, pd);
      reset = 1'b0;
      check("rnd_en", 32'(fb_wr_en), 32'(m_en));
      check("rnd_addr", 32'(fb_addr), 32'(m_addr));
      check("rnd_data", 32'(fb_wr_data), 32'(m_data));
      check("rnd_grant", 32'(grant_id), 32'(m_grant));
      check("rnd_locked", 32'(locked), 32'(m_locked));
      check("rnd_drop", 32'(drop_count), 32'(m_drop));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
